// File: rtl/axi_memory_responder.sv
// axi_memory_responder: AXI4 subordinate backed by a word-addressed memory array.
// Ports: data_aclock/data_areset (clock, sync active-high reset); AW/W/B write
// channels and AR/R read channels. Each direction handles one burst at a time.
module axi_memory_responder #(
    parameter int ID_WIDTH   = 24,
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 256
) (
    input  logic                      data_aclock,
    input  logic                      data_areset,
    input  logic [ID_WIDTH-1:0]       data_awid,
    input  logic [ADDR_WIDTH-1:0]     data_awaddr,
    input  logic [7:0]                data_awlen,
    input  logic [2:0]                data_awsize,
    input  logic [1:0]                data_awburst,
    input  logic [2:0]                data_awprot,
    input  logic [3:0]                data_awqos,
    input  logic                      data_awvalid,
    output logic                      data_awready,
    input  logic [DATA_WIDTH-1:0]     data_wdata,
    input  logic [DATA_WIDTH/8-1:0]   data_wstrb,
    input  logic                      data_wlast,
    input  logic                      data_wvalid,
    output logic                      data_wready,
    output logic [ID_WIDTH-1:0]       data_bid,
    output logic [1:0]                data_bresp,
    output logic                      data_bvalid,
    input  logic                      data_bready,
    input  logic [ID_WIDTH-1:0]       data_arid,
    input  logic [ADDR_WIDTH-1:0]     data_araddr,
    input  logic [7:0]                data_arlen,
    input  logic [2:0]                data_arsize,
    input  logic [1:0]                data_arburst,
    input  logic [2:0]                data_arprot,
    input  logic [3:0]                data_arqos,
    input  logic                      data_arvalid,
    output logic                      data_arready,
    output logic [ID_WIDTH-1:0]       data_rid,
    output logic [DATA_WIDTH-1:0]     data_rdata,
    output logic [1:0]                data_rresp,
    output logic                      data_rlast,
    output logic                      data_rvalid,
    input  logic                      data_rready
);
    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam int OFF        = $clog2(DATA_BYTES);
    localparam int IDXW       = $clog2(DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    w_state_t              w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d, w_step;
    logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [2:0]            w_size_q, w_size_d;
    logic                  w_incr_q, w_incr_d, w_bad_q, w_bad_d;
    logic                  w_slv_q, w_slv_d, w_dec_q, w_dec_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  w_oor, w_hs, w_we, w_last_beat, w_slv_n, w_dec_n;

    r_state_t              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d, r_step, r_ld_addr;
    logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [2:0]            r_size_q, r_size_d;
    logic                  r_incr_q, r_incr_d, r_bad_q, r_bad_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rlast_q, rlast_d;
    logic                  r_ld, r_ld_bad, r_ld_oor;

    logic unused_ok;
    assign unused_ok = ^{data_awprot, data_awqos, data_arprot, data_arqos};

    assign data_awready = w_state_q == W_IDLE;
    assign data_wready  = w_state_q == W_DATA;
    assign data_bvalid  = w_state_q == W_RESP;
    assign data_bid     = bid_q;
    assign data_bresp   = bresp_q;
    assign data_arready = r_state_q == R_IDLE;
    assign data_rvalid  = r_state_q == R_DATA;
    assign data_rid     = rid_q;
    assign data_rdata   = rdata_q;
    assign data_rresp   = rresp_q;
    assign data_rlast   = rlast_q;

    // Write path: the burst length, not wlast, decides when the burst ends.
    always_comb begin
        w_state_d   = w_state_q;
        bid_d       = bid_q;
        w_addr_d    = w_addr_q;
        w_len_d     = w_len_q;
        w_cnt_d     = w_cnt_q;
        w_size_d    = w_size_q;
        w_incr_d    = w_incr_q;
        w_bad_d     = w_bad_q;
        w_slv_d     = w_slv_q;
        w_dec_d     = w_dec_q;
        bresp_d     = bresp_q;
        w_oor       = |w_addr_q[ADDR_WIDTH-1:OFF+IDXW];
        w_step      = ADDR_WIDTH'(1) << w_size_q;
        w_hs        = (w_state_q == W_DATA) && data_wvalid;
        w_we        = w_hs && !w_oor && !w_bad_q && !data_areset;
        w_last_beat = w_cnt_q == w_len_q;
        w_dec_n     = w_dec_q | w_oor;
        w_slv_n     = w_slv_q | (data_wlast != w_last_beat);
        if (w_state_q == W_IDLE && data_awvalid) begin
            w_state_d = W_DATA;
            bid_d     = data_awid;
            w_addr_d  = data_awaddr;
            w_len_d   = data_awlen;
            w_size_d  = data_awsize;
            w_incr_d  = data_awburst == 2'b01;
            w_bad_d   = data_awburst[1];
            w_cnt_d   = '0;
            w_slv_d   = 1'b0;
            w_dec_d   = 1'b0;
        end else if (w_hs) begin
            w_addr_d  = w_incr_q ? w_addr_q + w_step : w_addr_q;
            w_cnt_d   = w_cnt_q + 8'd1;
            w_slv_d   = w_slv_n;
            w_dec_d   = w_dec_n;
            w_state_d = w_last_beat ? W_RESP : W_DATA;
            bresp_d   = !w_last_beat ? bresp_q :
                        w_dec_n ? 2'b11 : (w_slv_n || w_bad_q) ? 2'b10 : 2'b00;
        end else if (w_state_q == W_RESP && data_bready) begin
            w_state_d = W_IDLE;
        end
    end

    // Read path: rdata is registered, so each handshake preloads the next beat.
    // Reading mem here sees pre-write contents when a write commits the same cycle.
    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_size_d  = r_size_q;
        r_incr_d  = r_incr_q;
        r_bad_d   = r_bad_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        r_step    = ADDR_WIDTH'(1) << r_size_q;
        r_ld      = 1'b0;
        r_ld_addr = r_incr_q ? r_addr_q + r_step : r_addr_q;
        r_ld_bad  = r_bad_q;
        if (r_state_q == R_IDLE && data_arvalid) begin
            r_state_d = R_DATA;
            rid_d     = data_arid;
            r_len_d   = data_arlen;
            r_size_d  = data_arsize;
            r_incr_d  = data_arburst == 2'b01;
            r_bad_d   = data_arburst[1];
            r_cnt_d   = '0;
            r_ld      = 1'b1;
            r_ld_addr = data_araddr;
            r_ld_bad  = data_arburst[1];
        end else if (r_state_q == R_DATA && data_rready) begin
            r_state_d = rlast_q ? R_IDLE : R_DATA;
            r_ld      = !rlast_q;
            r_cnt_d   = rlast_q ? r_cnt_q : r_cnt_q + 8'd1;
        end
        r_ld_oor = |r_ld_addr[ADDR_WIDTH-1:OFF+IDXW];
        if (r_ld) begin
            r_addr_d = r_ld_addr;
            rdata_d  = (r_ld_oor || r_ld_bad) ? '0 : mem[r_ld_addr[OFF +: IDXW]];
            rresp_d  = r_ld_oor ? 2'b11 : r_ld_bad ? 2'b10 : 2'b00;
            rlast_d  = r_cnt_d == r_len_d;
        end
    end

    always_ff @(posedge data_aclock) begin
        if (data_areset) begin
            w_state_q <= W_IDLE;
            bid_q     <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_size_q  <= '0;
            w_incr_q  <= 1'b0;
            w_bad_q   <= 1'b0;
            w_slv_q   <= 1'b0;
            w_dec_q   <= 1'b0;
            bresp_q   <= '0;
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_size_q  <= '0;
            r_incr_q  <= 1'b0;
            r_bad_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            bid_q     <= bid_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_size_q  <= w_size_d;
            w_incr_q  <= w_incr_d;
            w_bad_q   <= w_bad_d;
            w_slv_q   <= w_slv_d;
            w_dec_q   <= w_dec_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            rid_q     <= rid_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_size_q  <= r_size_d;
            r_incr_q  <= r_incr_d;
            r_bad_q   <= r_bad_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    // Memory is deliberately not reset; committed bytes survive a reset.
    always_ff @(posedge data_aclock) begin
        for (int b = 0; b < DATA_BYTES; b++)
            if (w_we && data_wstrb[b])
                mem[w_addr_q[OFF +: IDXW]][b*8 +: 8] <= data_wdata[b*8 +: 8];
    end
endmodule
